// File: rtl/sram_skew_feeder_pkg.sv
// Shared constants and FSM encoding for the SRAM skew feeder.
package sram_skew_feeder_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 3;
    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_skew_feeder_if.sv
// Sequencer handshake, SRAM port A and skewed lane outputs of the feeder.
interface sram_skew_feeder_if #(
    parameter int unsigned ADDR_W = sram_skew_feeder_pkg::ADDR_W,
    parameter int unsigned LANE_W = sram_skew_feeder_pkg::LANE_W,
    parameter int unsigned LANES  = sram_skew_feeder_pkg::LANES
);
    localparam int unsigned DATA_W = LANES * LANE_W;

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   len_m1;
    logic                busy;
    logic                done;
    logic                sram_en;
    logic                sram_we;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_rdata;
    logic [DATA_W-1:0]   lane_data;
    logic [LANES-1:0]    lane_valid;

    // Environment side: sequencer plus SRAM read data.
    modport master (
        output start, base_addr, len_m1, sram_rdata,
        input  busy, done, sram_en, sram_we, sram_addr, lane_data, lane_valid
    );

    // Feeder side.
    modport slave (
        input  start, base_addr, len_m1, sram_rdata,
        output busy, done, sram_en, sram_we, sram_addr, lane_data, lane_valid
    );

endinterface

// File: rtl/sram_skew_feeder_skew_delay_line.sv
// DEPTH-stage register chain with valid; invalid entries carry zero data.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             dly_valid,
    output logic [WIDTH-1:0] dly_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk | rst;
            assign dly_valid = src_valid;
            assign dly_data  = src_valid ? src_data : '0;
        end else begin : g_chain
            logic [DEPTH-1:0] v_q;
            logic [WIDTH-1:0] d_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= src_valid;
                    d_q[0] <= src_valid ? src_data : '0;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign dly_valid = v_q[DEPTH-1];
            assign dly_data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/sram_skew_feeder.sv
// Reads a run of SRAM words and emits their bytes on LANES lanes,
// lane k delayed k cycles, to feed the edge of a systolic array.
module sram_skew_feeder #(
    parameter int unsigned ADDR_W = sram_skew_feeder_pkg::ADDR_W,
    parameter int unsigned LANE_W = sram_skew_feeder_pkg::LANE_W,
    parameter int unsigned LANES  = sram_skew_feeder_pkg::LANES
) (
    input  logic              clk,
    input  logic              rst,
    sram_skew_feeder_if.slave bus
);
    import sram_skew_feeder_pkg::*;

    localparam int unsigned DATA_W    = LANES * LANE_W;
    // SRAM latency + stage 0 + deepest skew chain.
    localparam int unsigned DRAIN_LEN = RD_LAT + 1 + (LANES - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [ADDR_W-1:0] cnt_q, cnt_nxt;
    logic              rd_v;
    logic              s0_v;
    logic [DATA_W-1:0] s0_data;
    logic [LANES-1:0]  lane_valid_w;
    logic [DATA_W-1:0] lane_data_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // The count register is reused as the drain timer once reads finish.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_nxt  = bus.base_addr;
                    cnt_nxt   = bus.len_m1;
                    state_nxt = READ;
                end
            end
            READ: begin
                addr_nxt = addr_q + ADDR_W'(1);
                if (cnt_q == '0) begin
                    cnt_nxt   = ADDR_W'(DRAIN_LEN - 1);
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt_q - ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - ADDR_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.sram_en   = (state == READ);
    assign bus.sram_we   = 1'b0;
    assign bus.sram_addr = addr_q;
    assign bus.busy      = (state == READ) || (state == DRAIN);
    assign bus.done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v    <= 1'b0;
            s0_v    <= 1'b0;
            s0_data <= '0;
        end else begin
            rd_v    <= bus.sram_en;
            s0_v    <= rd_v;
            s0_data <= rd_v ? bus.sram_rdata : '0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            skew_delay_line #(
                .DEPTH(k),
                .WIDTH(LANE_W)
            ) u_dly (
                .clk      (clk),
                .rst      (rst),
                .src_valid(s0_v),
                .src_data (s0_data[k*LANE_W +: LANE_W]),
                .dly_valid(lane_valid_w[k]),
                .dly_data (lane_data_w[k*LANE_W +: LANE_W])
            );
        end
    endgenerate

    assign bus.lane_valid = lane_valid_w;
    assign bus.lane_data  = lane_data_w;

endmodule

// File: tb/tb_sram_skew_feeder.sv
// Scoreboard bench for sram_skew_feeder with a registered-read SRAM model.
module tb_sram_skew_feeder;

    typedef struct {
        int unsigned lane;
        logic [7:0]  b;
        int unsigned c;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [23:0] mem [256];
    exp_t        sb [$];

    sram_skew_feeder_if bus ();

    sram_skew_feeder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.sram_en) bus.sram_rdata <= mem[bus.sram_addr];
    end

    // Lane k of word i is due in job cycle 3+i+k; t1 is the cyc value of job cycle 1.
    function automatic void push_job(input logic [7:0] base, input int unsigned n,
                                     input int unsigned t1);
        exp_t        e;
        logic [7:0]  a;
        logic [23:0] w;
        for (int unsigned d = 0; d < n + 2; d++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (d >= k && d - k < n) begin
                    a      = base + 8'(d - k);
                    w      = mem[a];
                    e.lane = k;
                    e.b    = w[8*k +: 8];
                    e.c    = t1 + 2 + d;
                    sb.push_back(e);
                end
            end
        end
    endfunction

    always @(negedge clk) begin : mon
        logic [2:0]  wv;
        logic [23:0] wd;
        exp_t        e;
        wv = '0;
        wd = '0;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            wv[e.lane] = 1'b1;
            wd[8*e.lane +: 8] = e.b;
        end
        total++;
        if ({bus.lane_valid, bus.lane_data} !== {wv, wd}) begin
            bad++;
            $display("FAIL lanes cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                     cyc, bus.lane_valid, bus.lane_data, wv, wd);
        end
        total++;
        if (bus.sram_we !== 1'b0) begin
            bad++;
            $display("FAIL sram_we cyc=%0d got=%b want=0", cyc, bus.sram_we);
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sram_en, bus.sram_we, bus.sram_addr,
             bus.lane_valid, bus.lane_data} !== 39'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b en=%b addr=%h lv=%b ld=%h want all 0",
                     bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.lane_valid, bus.lane_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sram_en, bus.sram_addr} !== 11'd0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b en=%b addr=%h want 0",
                     bus.busy, bus.done, bus.sram_en, bus.sram_addr);
        end
    endtask

    // Runs one job from IDLE; optionally pokes a stray start (base 0x40) in job cycle 'poke'.
    task automatic test_job(input string name, input logic [7:0] base, input logic [7:0] len_m1,
                            input int unsigned poke, input int unsigned tail);
        int unsigned n;
        logic [7:0]  ea;
        logic [10:0] obs;
        logic [10:0] want;
        n = int'(len_m1) + 1;
        bus.base_addr = base;
        bus.len_m1    = len_m1;
        bus.start     = 1'b1;
        push_job(base, n, cyc + 1);
        @(posedge clk);
        #1;
        ea = base;
        for (int unsigned c = 1; c <= n + 5 + tail; c++) begin
            if (c == poke) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h40;
                bus.len_m1    = 8'h07;
            end else begin
                bus.start = 1'b0;
            end
            obs  = {bus.busy, bus.done, bus.sram_en, bus.sram_en ? bus.sram_addr : 8'h00};
            want = {c <= n + 4, c == n + 5, c <= n, (c <= n) ? ea : 8'h00};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL %s_cycle%0d got busy/done/en/addr=%h want=%h", name, c, obs, want);
            end
            if (c <= n) ea = ea + 8'd1;
            @(posedge clk);
            #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d unmatched lane elements want=0", name, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        test_job("b2b_a", 8'h20, 8'h01, 7, 0);
        test_job("b2b_b", 8'h40, 8'h02, 0, 3);
    endtask

    task automatic test_reset_mid;
        bus.base_addr = 8'h10;
        bus.len_m1    = 8'h03;
        bus.start     = 1'b1;
        push_job(8'h10, 4, cyc + 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.sram_en, bus.lane_valid} !== 5'b11011) begin
            bad++;
            $display("FAIL pre_reset got busy=%b en=%b lv=%b want 1 1 011",
                     bus.busy, bus.sram_en, bus.lane_valid);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sram_en, bus.sram_we, bus.sram_addr,
             bus.lane_valid, bus.lane_data} !== 39'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b en=%b addr=%h lv=%b ld=%h want all 0",
                     bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.lane_valid, bus.lane_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned c = 0; c < 10; c++) begin
            total++;
            if ({bus.busy, bus.done, bus.sram_en} !== 3'b000) begin
                bad++;
                $display("FAIL post_reset_quiet%0d got busy=%b done=%b en=%b want 0 0 0",
                         c, bus.busy, bus.done, bus.sram_en);
            end
            @(posedge clk);
            #1;
        end
        test_job("restart", 8'h10, 8'h03, 0, 2);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.len_m1     = '0;
        bus.sram_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i * 5 + 3), 8'(i * 11 + 7), 8'(i ^ 'hA5)};
        end
        mem[8'h10] = 24'h030201;
        mem[8'h11] = 24'h060504;
        mem[8'h12] = 24'h090807;
        mem[8'h13] = 24'h0C0B0A;

        test_reset;
        test_job("basic", 8'h10, 8'h03, 0, 2);
        test_job("wrap", 8'hFE, 8'h02, 0, 2);
        test_job("single", 8'h33, 8'h00, 0, 2);
        test_job("full", 8'h00, 8'hFF, 0, 2);
        test_job("busy_start", 8'h10, 8'h03, 2, 3);
        test_job("done_start", 8'h20, 8'h01, 7, 3);
        test_back_to_back;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
